// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin sharing of one UART word transmitter among
// NUM_REQ requesters. One word transfer per grant, completion ack per requester.
// Optional launch watchdog: define SERIAL_TX_ARB_WDOG_EN to enable it.
module serial_tx_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int WDOG_CYCLES = 1023
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [32*NUM_REQ-1:0]   req_word,
   input  logic [3*NUM_REQ-1:0]    req_bytes,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      ack,
   output logic                    busy,
   output logic                    err,
   output logic                    tx_start,
   input  logic                    tx_busy,
   output logic [31:0]             tx_word,
   output logic [2:0]              tx_bytes
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_param_check
      $error("serial_tx_arbiter: NUM_REQ must be 2..8 and WDOG_CYCLES >= 1");
   end

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [IDX_W-1:0]     win_q, win_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 tx_start_q, tx_start_d;
   logic [31:0]          tx_word_q, tx_word_d;
   logic [2:0]           tx_bytes_q, tx_bytes_d;

   logic                 pick_valid;
   logic [IDX_W-1:0]     pick_idx;
   logic [31:0]          sel_word;
   logic [2:0]           sel_bytes;

`ifdef SERIAL_TX_ARB_WDOG_EN
   localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_q, err_d;
`endif

   // Round-robin search: first requesting index after last_q, wrapping around.
   always_comb begin
      int cand;
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(last_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(cand);
         end
      end
   end

   assign sel_word  = req_word[32*int'(pick_idx) +: 32];
   assign sel_bytes = req_bytes[3*int'(pick_idx) +: 3];

   // Next-state and registered-output logic of the transaction sequencer.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      win_d      = win_q;
      gnt_d      = gnt_q;
      ack_d      = '0;
      tx_word_d  = tx_word_q;
      tx_bytes_d = tx_bytes_q;
`ifdef SERIAL_TX_ARB_WDOG_EN
      cnt_d      = cnt_q;
      err_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            // The cycle carrying ack still shows gnt; drop it here and
            // arbitrate only once the ack has gone, giving one idle gap.
            if (ack_q != '0) begin
               gnt_d = '0;
            end else if (pick_valid) begin
               win_d           = pick_idx;
               gnt_d           = '0;
               gnt_d[pick_idx] = 1'b1;
               tx_word_d       = sel_word;
               if (sel_bytes == 3'd0) begin
                  tx_bytes_d = 3'd0;
                  state_d    = DONE;
               end else begin
                  tx_bytes_d = (sel_bytes > 3'd4) ? 3'd4 : sel_bytes;
                  state_d    = LAUNCH;
`ifdef SERIAL_TX_ARB_WDOG_EN
                  cnt_d      = '0;
`endif
               end
            end
         end
         LAUNCH: begin
            if (tx_busy) begin
               state_d = WAIT;
            end else begin
`ifdef SERIAL_TX_ARB_WDOG_EN
               // Transmitter never answered: abandon, but still advance the
               // pointer so this requester cannot lock out the others.
               if (cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  err_d   = 1'b1;
                  last_d  = win_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
`endif
            end
         end
         WAIT: begin
            if (!tx_busy) state_d = DONE;
         end
         DONE: begin
            ack_d   = gnt_q;
            last_d  = win_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      tx_start_d = (state_d == LAUNCH);
   end

   // State and output registers; asynchronous reset abandons any transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_q     <= IDX_W'(NUM_REQ - 1);
         win_q      <= '0;
         gnt_q      <= '0;
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         tx_word_q  <= '0;
         tx_bytes_q <= '0;
`ifdef SERIAL_TX_ARB_WDOG_EN
         cnt_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         win_q      <= win_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         tx_start_q <= tx_start_d;
         tx_word_q  <= tx_word_d;
         tx_bytes_q <= tx_bytes_d;
`ifdef SERIAL_TX_ARB_WDOG_EN
         cnt_q      <= cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   assign gnt      = gnt_q;
   assign ack      = ack_q;
   assign busy     = (state_q != IDLE);
   assign tx_start = tx_start_q;
   assign tx_word  = tx_word_q;
   assign tx_bytes = tx_bytes_q;
`ifdef SERIAL_TX_ARB_WDOG_EN
   assign err      = err_q;
`else
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Testbench for serial_tx_arbiter: transaction-level round-robin model plus a
// simple transmitter model answering tx_start with a programmable busy pulse.
module tb_serial_tx_arbiter;

   localparam int N = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [32*N-1:0] req_word;
   logic [3*N-1:0]  req_bytes;
   logic [N-1:0]    gnt;
   logic [N-1:0]    ack;
   logic            busy;
   logic            err;
   logic            tx_start;
   logic            tx_busy;
   logic [31:0]     tx_word;
   logic [2:0]      tx_bytes;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int start_cycles = 0;
   int ack_pulses = 0;
   int onehot_viol = 0;
   int model_last = N - 1;

   bit tx_en = 1'b1;
   bit tx_abort = 1'b0;
   int busy_delay = 0;
   int busy_len = 1;

   serial_tx_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(15)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_word  (req_word),
      .req_bytes (req_bytes),
      .gnt       (gnt),
      .ack       (ack),
      .busy      (busy),
      .err       (err),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .tx_word   (tx_word),
      .tx_bytes  (tx_bytes)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_start === 1'b1) start_cycles <= start_cycles + 1;
      if (ack !== '0) ack_pulses <= ack_pulses + 1;
      if ($countones(gnt) > 1) onehot_viol <= onehot_viol + 1;
   end

   // Transmitter model: after seeing tx_start, raise busy busy_delay cycles
   // later and hold it busy_len cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1 && tx_en && rst_n === 1'b1) begin
            for (int i = 0; i < busy_delay && !tx_abort; i++) @(negedge clk);
            if (!tx_abort) tx_busy = 1'b1;
            for (int i = 0; i < busy_len && !tx_abort; i++) @(negedge clk);
            tx_busy = 1'b0;
         end
      end
   end

   // Spec rule: search (last+1), (last+2), ... modulo N.
   function automatic int rr_pick(input int last, input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (last + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [2:0] clamp_bytes(input logic [2:0] b);
      return (b > 3'd4) ? 3'd4 : b;
   endfunction

   task automatic set_src(input int idx, input logic [31:0] w, input logic [2:0] b);
      req_word[32*idx +: 32] = w;
      req_bytes[3*idx +: 3]  = b;
   endtask

   // Waits for the next grant and its ack, returning what was observed.
   task automatic observe_txn(input int budget, output logic [N-1:0] g, output logic [31:0] w,
                              output logic [2:0] b, output logic st, output logic [N-1:0] a,
                              output logic ab, output int gc, output int ac, output bit to);
      int n;
      g = '0; w = '0; b = '0; st = 1'b0; a = '0; ab = 1'b0; gc = 0; ac = 0; to = 1'b0;
      n = 0;
      while (gnt !== '0 && n < budget) begin @(negedge clk); n++; end
      while (gnt === '0 && n < budget) begin @(negedge clk); n++; end
      if (n >= budget) begin to = 1'b1; return; end
      g = gnt; w = tx_word; b = tx_bytes; st = tx_start; gc = cyc;
      while (ack === '0 && n < budget) begin @(negedge clk); n++; end
      if (ack === '0) begin to = 1'b1; return; end
      a = ack; ab = busy; ac = cyc;
   endtask

   task automatic test_reset();
      logic [N-1:0] g;
      req = '0; req_word = '0; req_bytes = '0; rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({gnt, ack, busy, err, tx_start, tx_word, tx_bytes} !== '0)
         $display("FAIL reset_outputs: got gnt=%b ack=%b busy=%b err=%b start=%b word=%h bytes=%0d expected all 0",
                  gnt, ack, busy, err, tx_start, tx_word, tx_bytes);
      else pass_cnt++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      g = gnt;
      total_cnt++;
      if (g !== '0 || busy !== 1'b0) $display("FAIL reset_idle: got gnt=%b busy=%b expected 0/0", g, busy);
      else pass_cnt++;
      model_last = N - 1;
      $display("txn reset: outputs cleared");
   endtask

   task automatic test_single();
      logic [N-1:0] g, a; logic [31:0] w; logic [2:0] b; logic st, ab; int gc, ac, c0; bit to;
      @(negedge clk);
      set_src(0, 32'h0000_02FF, 3'd2);
      busy_delay = 1; busy_len = 20;
      req = 3'b001; c0 = cyc;
      observe_txn(200, g, w, b, st, a, ab, gc, ac, to);
      req = '0;
      $display("txn single: gnt=%b word=%h bytes=%0d ack=%b cyc %0d->%0d", g, w, b, a, gc, ac);
      total_cnt++; if (to) $display("FAIL single_timeout: got timeout expected ack"); else pass_cnt++;
      total_cnt++; if (g !== 3'b001 || gc !== c0 + 1) $display("FAIL single_gnt: got %b at +%0d expected 001 at +1", g, gc - c0); else pass_cnt++;
      total_cnt++; if (st !== 1'b1) $display("FAIL single_start: got %b expected 1", st); else pass_cnt++;
      total_cnt++; if (w !== 32'h0000_02FF || b !== 3'd2) $display("FAIL single_word: got %h/%0d expected 000002ff/2", w, b); else pass_cnt++;
      total_cnt++; if (a !== 3'b001 || ac !== gc + 23) $display("FAIL single_ack: got %b at gnt+%0d expected 001 at gnt+23", a, ac - gc); else pass_cnt++;
      total_cnt++; if (ab !== 1'b0) $display("FAIL single_busy: got %b expected 0", ab); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (ack !== '0 || gnt !== '0) $display("FAIL single_after: got ack=%b gnt=%b expected 0/0", ack, gnt); else pass_cnt++;
      model_last = 0;
   endtask

   task automatic test_zero_bytes();
      logic [N-1:0] g, a; logic [31:0] w; logic [2:0] b; logic st, ab; int gc, ac, c0, s0; bit to;
      @(negedge clk);
      s0 = start_cycles;
      set_src(1, 32'h1234_5678, 3'd0);
      req = 3'b010; c0 = cyc;
      observe_txn(50, g, w, b, st, a, ab, gc, ac, to);
      req = '0;
      $display("txn zero_bytes: gnt=%b bytes=%0d ack=%b cyc %0d->%0d", g, b, a, gc, ac);
      total_cnt++; if (to || g !== 3'b010 || gc !== c0 + 1) $display("FAIL zero_gnt: got %b at +%0d expected 010 at +1", g, gc - c0); else pass_cnt++;
      total_cnt++; if (a !== 3'b010 || ac !== c0 + 2) $display("FAIL zero_ack: got %b at +%0d expected 010 at +2", a, ac - c0); else pass_cnt++;
      total_cnt++; if (b !== 3'd0) $display("FAIL zero_txbytes: got %0d expected 0", b); else pass_cnt++;
      repeat (2) @(negedge clk);
      #1;
      total_cnt++; if (start_cycles !== s0) $display("FAIL zero_nostart: got %0d start cycles expected %0d", start_cycles, s0); else pass_cnt++;
      model_last = 1;
      // Byte count above 4 is clamped.
      set_src(0, 32'hCAFE_0006, 3'd6);
      busy_delay = 0; busy_len = 3;
      req = 3'b001;
      observe_txn(100, g, w, b, st, a, ab, gc, ac, to);
      req = '0;
      $display("txn clamp: gnt=%b word=%h bytes=%0d ack=%b", g, w, b, a);
      total_cnt++; if (to || g !== 3'b001 || b !== 3'd4 || st !== 1'b1) $display("FAIL clamp_bytes: got gnt=%b bytes=%0d start=%b expected 001/4/1", g, b, st); else pass_cnt++;
      total_cnt++; if (a !== 3'b001) $display("FAIL clamp_ack: got %b expected 001", a); else pass_cnt++;
      model_last = 0;
   endtask

   task automatic test_drop_change();
      int n;
      @(negedge clk);
      set_src(2, 32'hA5A5_0003, 3'd3);
      busy_delay = 0; busy_len = 6;
      req = 3'b100;
      n = 0; while (gnt === '0 && n < 50) begin @(negedge clk); n++; end
      total_cnt++; if (gnt !== 3'b100) $display("FAIL drop_gnt: got %b expected 100", gnt); else pass_cnt++;
      n = 0; while (tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      req = '0;
      set_src(2, 32'hDEAD_BEEF, 3'd1);
      n = 0; while (ack === '0 && n < 50) begin @(negedge clk); n++; end
      $display("txn drop_change: word=%h bytes=%0d ack=%b", tx_word, tx_bytes, ack);
      total_cnt++; if (tx_word !== 32'hA5A5_0003 || tx_bytes !== 3'd3) $display("FAIL drop_latched: got %h/%0d expected a5a50003/3", tx_word, tx_bytes); else pass_cnt++;
      total_cnt++; if (ack !== 3'b100) $display("FAIL drop_ack: got %b expected 100", ack); else pass_cnt++;
      model_last = 2;
   endtask

   task automatic test_round_robin();
      logic [N-1:0] g, a; logic [31:0] w; logic [2:0] b; logic st, ab; int gc, ac, a0, v0, exp; bit to;
      logic [31:0] words [N];
      logic [2:0]  bytes [N];
      repeat (2) @(negedge clk);
      a0 = ack_pulses; v0 = onehot_viol;
      busy_delay = 1; busy_len = 2;
      for (int i = 0; i < N; i++) begin
         words[i] = $urandom; bytes[i] = 3'($urandom_range(1, 4));
         set_src(i, words[i], bytes[i]);
      end
      req = 3'b111;
      for (int t = 0; t < 4; t++) begin
         exp = rr_pick(model_last, 3'b111);
         observe_txn(100, g, w, b, st, a, ab, gc, ac, to);
         $display("txn rr%0d: gnt=%b word=%h bytes=%0d ack=%b expected winner %0d", t, g, w, b, a, exp);
         total_cnt++;
         if (to || g !== (N'(1) << exp) || w !== words[exp] || b !== bytes[exp] || a !== g)
            $display("FAIL rr_txn%0d: got gnt=%b word=%h bytes=%0d ack=%b expected winner %0d word=%h bytes=%0d",
                     t, g, w, b, a, exp, words[exp], bytes[exp]);
         else pass_cnt++;
         model_last = exp;
      end
      req = '0;
      repeat (2) @(negedge clk);
      total_cnt++; if (ack_pulses - a0 !== 4) $display("FAIL rr_ack_count: got %0d expected 4", ack_pulses - a0); else pass_cnt++;
      total_cnt++; if (onehot_viol !== v0) $display("FAIL rr_onehot: got %0d violations expected 0", onehot_viol - v0); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] g, a; logic [31:0] w; logic [2:0] b; logic st, ab; int gc, ac, n; bit to;
      @(negedge clk);
      set_src(1, 32'h0BAD_F00D, 3'd4);
      busy_delay = 0; busy_len = 30;
      req = 3'b010;
      n = 0; while (gnt === '0 && n < 50) begin @(negedge clk); n++; end
      n = 0; while (tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      tx_abort = 1'b1;
      rst_n = 1'b0;
      #1;
      $display("txn reset_mid: gnt=%b ack=%b busy=%b start=%b", gnt, ack, busy, tx_start);
      total_cnt++;
      if ({gnt, ack, busy, err, tx_start, tx_word, tx_bytes} !== '0)
         $display("FAIL resetmid_outputs: got gnt=%b ack=%b busy=%b start=%b word=%h expected all 0", gnt, ack, busy, tx_start, tx_word);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; tx_abort = 1'b0;
      model_last = N - 1;
      busy_delay = 0; busy_len = 2;
      req = 3'b111;
      observe_txn(100, g, w, b, st, a, ab, gc, ac, to);
      req = '0;
      $display("txn after_reset: gnt=%b ack=%b", g, a);
      total_cnt++; if (to || g !== 3'b001 || a !== 3'b001) $display("FAIL resetmid_priority: got gnt=%b ack=%b expected 001/001", g, a); else pass_cnt++;
      model_last = 0;
   endtask

   task automatic test_random();
      logic [N-1:0] g, a, pend; logic [31:0] w; logic [2:0] b; logic st, ab; int gc, ac, exp, lat; bit to;
      logic [31:0] words [N];
      logic [2:0]  bytes [N];
      for (int r = 0; r < 15; r++) begin
         pend = N'($urandom_range(1, (1 << N) - 1));
         busy_delay = $urandom_range(0, 3);
         busy_len = $urandom_range(1, 5);
         for (int i = 0; i < N; i++) begin
            words[i] = $urandom; bytes[i] = 3'($urandom_range(0, 7));
            set_src(i, words[i], bytes[i]);
         end
         req = pend;
         while (pend != '0) begin
            exp = rr_pick(model_last, pend);
            observe_txn(100, g, w, b, st, a, ab, gc, ac, to);
            lat = (bytes[exp] == 3'd0) ? 1 : busy_delay + busy_len + 2;
            $display("txn rand%0d: gnt=%b word=%h bytes=%0d ack=%b lat=%0d expected winner %0d", r, g, w, b, a, ac - gc, exp);
            total_cnt++;
            if (to || g !== (N'(1) << exp) || w !== words[exp] || b !== clamp_bytes(bytes[exp]) || a !== g || ac - gc !== lat)
               $display("FAIL rand_txn%0d: got gnt=%b word=%h bytes=%0d ack=%b lat=%0d expected winner %0d word=%h bytes=%0d lat=%0d",
                        r, g, w, b, a, ac - gc, exp, words[exp], clamp_bytes(bytes[exp]), lat);
            else pass_cnt++;
            pend[exp] = 1'b0;
            req = pend;
            model_last = exp;
            if (to) pend = '0;
         end
      end
      req = '0;
   endtask

`ifdef SERIAL_TX_ARB_WDOG_EN
   task automatic test_watchdog();
      logic [N-1:0] g, a; logic [31:0] w; logic [2:0] b; logic st, ab; int gc, ac, ec, n, exp1, exp2, a0; bit to;
      repeat (2) @(negedge clk);
      a0 = ack_pulses;
      tx_en = 1'b0;
      set_src(0, 32'h1111_0001, 3'd1);
      set_src(1, 32'h2222_0002, 3'd2);
      exp1 = rr_pick(model_last, 3'b011);
      req = 3'b011;
      n = 0; while (gnt === '0 && n < 50) begin @(negedge clk); n++; end
      gc = cyc; g = gnt;
      n = 0; while (err !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      ec = cyc;
      $display("txn watchdog: gnt=%b err at gnt+%0d gnt_now=%b", g, ec - gc, gnt);
      total_cnt++; if (err !== 1'b1 || ec - gc !== 15 || g !== (N'(1) << exp1)) $display("FAIL wdog_err: got err=%b at +%0d gnt=%b expected 1 at +15", err, ec - gc, g); else pass_cnt++;
      total_cnt++; if (gnt !== '0 || ack_pulses !== a0) $display("FAIL wdog_noack: got gnt=%b acks=%0d expected 0/0", gnt, ack_pulses - a0); else pass_cnt++;
      req[exp1] = 1'b0;
      tx_en = 1'b1; busy_delay = 1; busy_len = 2;
      model_last = exp1;
      exp2 = rr_pick(model_last, req);
      observe_txn(100, g, w, b, st, a, ab, gc, ac, to);
      req = '0;
      total_cnt++; if (to || g !== (N'(1) << exp2) || a !== g) $display("FAIL wdog_next: got gnt=%b ack=%b expected winner %0d", g, a, exp2); else pass_cnt++;
      model_last = exp2;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_zero_bytes();
      test_drop_change();
      test_round_robin();
      test_reset_mid();
      test_random();
`ifdef SERIAL_TX_ARB_WDOG_EN
      test_watchdog();
`endif
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Round-robin arbiter that shares the single UART word transmitter among several requesters. The transmitter takes a 32-bit word and a byte count of 1..4, with a start/busy handshake.
- Typical requesters: frame sender, debug/status reporter, calibration dumper.
- Owns the transmitter's start/word/bytes inputs. Sequences one word transfer per grant and returns a per-requester completion pulse.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- WDOG_CYCLES, 1023, max cycles in LAUNCH waiting for tx_busy (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  level request per requester
- req_word  in  32*NUM_REQ  word for requester i at bits [32i+31:32i]
- req_bytes  in  3*NUM_REQ  byte count for requester i at bits [3i+2:3i]
- gnt  out  NUM_REQ  one-hot, high for the whole transaction of the granted requester
- ack  out  NUM_REQ  one-cycle pulse to the granted requester at transaction end
- busy  out  1  high whenever state != IDLE
- err  out  1  one-cycle pulse on watchdog abort (tied 0 without the optional feature)
- tx_start  out  1  transmitter start
- tx_busy  in  1  transmitter busy
- tx_word  out  32  word to transmitter, registered
- tx_bytes  out  3  byte count to transmitter, registered

Behaviour:
- Reset (async):
  - state=IDLE; gnt=0, ack=0, err=0, tx_start=0, tx_word=0, tx_bytes=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction abandons it immediately; no ack is issued.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - If any req bit is set, pick the first set bit searching (last+1), (last+2), ... modulo NUM_REQ.
  - Next cycle: gnt one-hot for the winner; tx_word and tx_bytes latched from the winner's inputs.
  - req_bytes rule: 0 -> state=DONE with no transmitter activity; 5..7 -> clamped to 4; 1..4 -> state=LAUNCH.
- LAUNCH:
  - tx_start=1, registered and derived from state.
  - On the first cycle tx_busy is sampled 1 -> WAIT; tx_start drops on entry to WAIT.
- WAIT: tx_start=0; on tx_busy sampled 0 -> DONE.
- DONE:
  - ack[winner]=1 for exactly one cycle; gnt still high this cycle.
  - last=winner; next cycle gnt=0, state=IDLE.
- Minimum gap between grants: one IDLE cycle.
- Latency from req assertion in IDLE:
  - gnt and tx_start at +1 cycle.
  - For the bytes=0 path, ack at +2 cycles.
- req dropped mid-transaction: ignored; the transfer completes and ack is still issued.
- req still high in the IDLE cycle after ack: treated as a new request, arbitrated fairly against the others.
- req_word/req_bytes changes after the grant cycle are ignored; values are latched once.
- Simultaneous requests: strict round-robin. No requester wins twice in a row while another is requesting.
- tx_busy high while in IDLE: no effect on arbitration. LAUNCH waits for tx_busy high as normal.

Optional Feature:
- Macro SERIAL_TX_ARB_WDOG_EN.
- When defined:
  - A counter runs in LAUNCH and is cleared on LAUNCH entry.
  - If WDOG_CYCLES cycles pass without tx_busy, go to IDLE, pulse err for one cycle, and drop gnt.
  - No ack is issued; last is updated to the winner so the requester does not starve the others.
- When undefined: no counter; err is tied 0; LAUNCH waits indefinitely.

Test Plan:
- Single request, req[0]=1, word=0x000002FF, bytes=2; transmitter model: busy 1 cycle after start, for 20 cycles -> gnt[0] at +1, tx_word=0x000002FF, tx_bytes=2, ack[0] pulses once after busy falls, busy returns 0.
- req=3'b111, each held until its own ack -> grant order 0,1,2,0; exactly one ack per transaction; gnt always one-hot.
- req[1]=1 with bytes=0 -> tx_start never asserted, ack[1] exactly 2 cycles after req; bytes=6 -> tx_bytes=4.
- req[2] dropped during WAIT and req_word[2] changed -> tx_word unchanged, ack[2] still pulses.
- rst_n asserted during WAIT -> all outputs 0 immediately; next request from requester 0 is granted first.
- With SERIAL_TX_ARB_WDOG_EN, WDOG_CYCLES=15, tx_busy stuck 0 -> err pulse 15 cycles after LAUNCH entry, no ack, next pending requester granted.
